seq_divider_ctrl: RTL and testbench

//  Multi-cycle unsigned 64-bit restoring divider. Sequences one shared

---
 rtl/seq_divider_ctrl_if.sv | 25 ++
 rtl/seq_divider_ctrl.sv | 152 +++++++++++++++
 tb/tb_seq_divider_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_ctrl_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
// The execute stage drives the master side; the divider is the slave.
interface seq_divider_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic             cancel;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, cancel, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, cancel, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_ctrl.sv
// Multi-cycle unsigned restoring divider: one shared subtractor, one
// quotient bit per cycle, start/busy/done handshake with flush cancel.
module adder_subtractor #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);
    logic [WIDTH:0] sum;

    // carry_out == 1 on subtract means no borrow (a >= b)
    assign sum       = {1'b0, a} + {1'b0, b ^ {WIDTH{sub}}} + {{WIDTH{1'b0}}, sub};
    assign result    = sum[WIDTH-1:0];
    assign carry_out = sum[WIDTH];
endmodule

module seq_divider_ctrl #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    seq_divider_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quo_work_q, quo_work_d;
    logic [WIDTH-1:0] rem_work_q, rem_work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] diff;
    logic             carry_out;
    logic             take;
    logic             accept;

    assign shifted = {rem_work_q[WIDTH-2:0], quo_work_q[WIDTH-1]};

    adder_subtractor #(.WIDTH(WIDTH)) u_addsub (
        .a         (shifted),
        .b         (divisor_q),
        .sub       (1'b1),
        .result    (diff),
        .carry_out (carry_out)
    );

    // A set top bit means the shifted value exceeds any 64-bit divisor
    assign take   = rem_work_q[WIDTH-1] | carry_out;
    assign accept = (state_q != RUN) && bus.start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            divisor_q   <= '0;
            quo_work_q  <= '0;
            rem_work_q  <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            divisor_q   <= divisor_d;
            quo_work_q  <= quo_work_d;
            rem_work_q  <= rem_work_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = (bus.divisor == '0) ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        divisor_d   = divisor_q;
        quo_work_d  = quo_work_q;
        rem_work_d  = rem_work_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        busy_d      = (state_d == RUN);

        if (accept) begin
            if (bus.divisor == '0) begin
                quotient_d  = '1;
                remainder_d = bus.dividend;
                dbz_d       = 1'b1;
                done_d      = 1'b1;
            end else begin
                divisor_d  = bus.divisor;
                quo_work_d = bus.dividend;
                rem_work_d = '0;
                cnt_d      = '0;
            end
        end else if (state_q == RUN && !bus.cancel) begin
            rem_work_d = take ? diff : shifted;
            quo_work_d = {quo_work_q[WIDTH-2:0], take};
            cnt_d      = cnt_q + CNT_W'(1);
            // Results publish from the final iteration's next values directly
            if (cnt_q == LAST_CNT) begin
                quotient_d  = quo_work_d;
                remainder_d = rem_work_d;
                dbz_d       = 1'b0;
                done_d      = 1'b1;
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Directed and scoreboarded checks of the sequential divider: latency,
// divide-by-zero, cancel, async reset, back-to-back starts, random operands.
module tb_seq_divider_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_divider_ctrl_if bus ();

    seq_divider_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op; lat is the cycle after the accepting edge in which done is seen
    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          output int lat, output int busy_n);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat    = -1;
        busy_n = 0;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        $display("op %h / %h -> q=%h r=%h dbz=%0d lat=%0d busy=%0d",
                 a, b, bus.quotient, bus.remainder, bus.div_by_zero, lat, busy_n);
    endtask

    task automatic check_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] eq, input logic [63:0] er, input logic edbz);
        int lat;
        int busy_n;
        run_op(a, b, lat, busy_n);
        check({tag, "_lat"}, 64'(lat), (b == 64'd0) ? 64'd1 : 64'd65);
        check({tag, "_busy"}, 64'(busy_n), (b == 64'd0) ? 64'd0 : 64'd64);
        check({tag, "_q"}, bus.quotient, eq);
        check({tag, "_r"}, bus.remainder, er);
        check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(edbz));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        int          d1;
        int          d2;
        int          done_seen;

        bus.start    = 1'b0;
        bus.cancel   = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        #12;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_q", bus.quotient, 64'd0);
        check("rst_r", bus.remainder, 64'd0);
        check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        check_op("d100_7", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0);
        check_op("top_bit", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
                 64'd1, 64'h7FFF_FFFF_FFFF_FFFE, 1'b0);
        check_op("near_max", 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        check_op("dbz", 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1);
        check_op("d9_3", 64'd9, 64'd3, 64'd3, 64'd0, 1'b0);

        // Ignored start while busy, then cancel
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 64'd100;
        bus.divisor  = 64'd7;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 2; c <= 11; c++) begin
            @(negedge clk);
            if (c == 3) begin
                bus.start    = 1'b1;
                bus.dividend = 64'd50;
                bus.divisor  = 64'd5;
            end
            if (c == 4) bus.start = 1'b0;
            if (c == 10) begin
                check("cancel_busy_before", 64'(bus.busy), 64'd1);
                bus.cancel = 1'b1;
            end
            if (c == 11) begin
                check("cancel_busy_after", 64'(bus.busy), 64'd0);
                bus.cancel = 1'b0;
            end
        end
        done_seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        $display("cancel: done pulses=%0d q=%h r=%h", done_seen, bus.quotient, bus.remainder);
        check("cancel_no_done", 64'(done_seen), 64'd0);
        check("cancel_hold_q", bus.quotient, 64'd3);
        check("cancel_hold_r", bus.remainder, 64'd0);
        check("cancel_hold_dbz", 64'(bus.div_by_zero), 64'd0);
        check_op("d50_5", 64'd50, 64'd5, 64'd10, 64'd0, 1'b0);

        // Asynchronous reset mid-run
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 64'd100;
        bus.divisor  = 64'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (29) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        $display("async reset: busy=%0d q=%h r=%h", bus.busy, bus.quotient, bus.remainder);
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_q", bus.quotient, 64'd0);
        check("arst_r", bus.remainder, 64'd0);
        check("arst_dbz", 64'(bus.div_by_zero), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check_op("post_rst", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0);

        // start held through done: back-to-back ops
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 64'd100;
        bus.divisor  = 64'd7;
        d1 = -1;
        d2 = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (d1 < 0) begin
                    d1 = c;
                    check("b2b_q1", bus.quotient, 64'd14);
                    check("b2b_r1", bus.remainder, 64'd2);
                    bus.dividend = 64'd1000;
                    bus.divisor  = 64'd9;
                end else begin
                    d2 = c;
                    check("b2b_q2", bus.quotient, 64'd111);
                    check("b2b_r2", bus.remainder, 64'd1);
                    break;
                end
            end
            if (d1 > 0 && c == d1 + 1) begin
                bus.start = 1'b0;
                check("b2b_busy2", 64'(bus.busy), 64'd1);
            end
        end
        $display("back-to-back: done at %0d and %0d", d1, d2);
        check("b2b_first", 64'(d1), 64'd65);
        check("b2b_gap", 64'(d2 - d1), 64'd65);
        bus.start = 1'b0;

        // Random operands against the native operators
        for (int i = 0; i < 200; i++) begin
            a = {$urandom, $urandom} >> $urandom_range(0, 40);
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (i % 50 == 7) b = 64'd0;
            if (b == 64'd0)
                check_op("rand", a, b, 64'hFFFF_FFFF_FFFF_FFFF, a, 1'b1);
            else
                check_op("rand", a, b, a / b, a % b, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
